// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined RV32I controller: ALU codes, immediate formats,
// result sources, opcodes, the per-instruction control bundle and small helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // An all-zero bundle is a bubble: nothing is written, stored or redirected.
    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        target_src;
        alu_op_t     alu_control;
        logic        alu_src;
    } ctrl_bundle_t;

    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use stall, redirect flush/priority and
// EX-stage operand forwarding selects.
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  load_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  use_rs1_d,
    input  logic                  use_rs2_d,
    input  logic                  pc_src_e,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);
    import ctrl_pkg::*;

    logic load_use;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic wm, input logic [REG_ADDR_W-1:0] dm,
                                           input logic ww, input logic [REG_ADDR_W-1:0] dw);
        logic [1:0] sel;
        if (wm && (dm != '0) && (dm == rs))
            sel = FWD_MEM;
        else if (ww && (dw != '0) && (dw == rs))
            sel = FWD_WB;
        else
            sel = FWD_REG;
        return sel;
    endfunction

    // A taken redirect overrides the stall so the wrong-path instruction is dropped.
    always_comb begin
        load_use = load_e && (rd_e != '0) &&
                   ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
        stall_f  = load_use && !pc_src_e;
        stall_d  = load_use && !pc_src_e;
        flush_d  = pc_src_e;
        flush_e  = load_use || pc_src_e;
        fwd_a    = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
        fwd_b    = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipelined RV32I controller: ID decode, ID/EX, EX/MEM, MEM/WB control registers.
// Define PIPE_CTRL_PERF_EN to add stall/redirect cycle counters.
module pipeline_controller #(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           instr_d_i,
    input  logic                  zero_e_i,
    input  logic                  lt_e_i,
    input  logic                  ltu_e_i,
    output logic [2:0]            imm_src_d_o,
    output logic                  illegal_d_o,
    output logic                  stall_f_o,
    output logic                  stall_d_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic [ALU_CTRL_W-1:0] alu_control_e_o,
    output logic                  alu_src_e_o,
    output logic [1:0]            fwd_a_e_o,
    output logic [1:0]            fwd_b_e_o,
    output logic                  pc_src_e_o,
    output logic                  pc_target_src_e_o,
    output logic                  mem_write_m_o,
    output logic                  reg_write_m_o,
    output logic [REG_ADDR_W-1:0] rd_m_o,
    output logic [1:0]            result_src_w_o,
    output logic                  reg_write_w_o,
    output logic [REG_ADDR_W-1:0] rd_w_o
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);
    import ctrl_pkg::*;

    logic [6:0]            opcode;
    logic [2:0]            funct3_d;
    logic [6:0]            funct7_d;
    logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
    ctrl_bundle_t          bundle_d;
    imm_src_t              imm_src_d;
    logic                  illegal_d, use_rs1_d, use_rs2_d;

    ctrl_bundle_t          bundle_e;
    logic [2:0]            funct3_e;
    logic [REG_ADDR_W-1:0] rd_e, rs1_e, rs2_e;
    result_src_t           result_src_m;

    assign opcode   = instr_d_i[6:0];
    assign funct3_d = instr_d_i[14:12];
    assign funct7_d = instr_d_i[31:25];
    assign rs1_d    = REG_ADDR_W'(instr_d_i[19:15]);
    assign rs2_d    = REG_ADDR_W'(instr_d_i[24:20]);

    // Anything not recognised collapses to a bubble so no X or stray write escapes.
    always_comb begin
        bundle_d  = '0;
        imm_src_d = IMM_I;
        illegal_d = 1'b0;
        use_rs1_d = 1'b0;
        use_rs2_d = 1'b0;
        case (opcode)
            OP_LOAD: begin
                bundle_d.reg_write  = 1'b1;
                bundle_d.alu_src    = 1'b1;
                bundle_d.result_src = RES_MEM;
                use_rs1_d = 1'b1;
                illegal_d = (funct3_d != 3'b010);
            end
            OP_STORE: begin
                imm_src_d          = IMM_S;
                bundle_d.alu_src   = 1'b1;
                bundle_d.mem_write = 1'b1;
                use_rs1_d = 1'b1;
                use_rs2_d = 1'b1;
                illegal_d = (funct3_d != 3'b010);
            end
            OP_REG: begin
                bundle_d.reg_write   = 1'b1;
                bundle_d.alu_control = alu_from_funct3(funct3_d, funct7_d[5]);
                use_rs1_d = 1'b1;
                use_rs2_d = 1'b1;
                illegal_d = !((funct7_d == 7'b0000000) ||
                              ((funct7_d == 7'b0100000) && ((funct3_d == 3'b000) || (funct3_d == 3'b101))));
            end
            OP_IMM: begin
                bundle_d.reg_write   = 1'b1;
                bundle_d.alu_src     = 1'b1;
                bundle_d.alu_control = alu_from_funct3(funct3_d, (funct3_d == 3'b101) && funct7_d[5]);
                use_rs1_d = 1'b1;
                illegal_d = ((funct3_d == 3'b001) && (funct7_d != 7'b0000000)) ||
                            ((funct3_d == 3'b101) && (funct7_d != 7'b0000000) && (funct7_d != 7'b0100000));
            end
            OP_BRANCH: begin
                imm_src_d            = IMM_B;
                bundle_d.branch      = 1'b1;
                bundle_d.alu_control = ALU_SUB;
                use_rs1_d = 1'b1;
                use_rs2_d = 1'b1;
                illegal_d = (funct3_d[2:1] == 2'b01);
            end
            OP_JAL: begin
                imm_src_d           = IMM_J;
                bundle_d.reg_write  = 1'b1;
                bundle_d.result_src = RES_PC4;
                bundle_d.jump       = 1'b1;
            end
            OP_JALR: begin
                bundle_d.reg_write   = 1'b1;
                bundle_d.alu_src     = 1'b1;
                bundle_d.alu_control = ALU_ADD;
                bundle_d.result_src  = RES_PC4;
                bundle_d.jump        = 1'b1;
                bundle_d.target_src  = 1'b1;
                use_rs1_d = 1'b1;
                illegal_d = (funct3_d != 3'b000);
            end
            OP_LUI: begin
                imm_src_d            = IMM_U;
                bundle_d.reg_write   = 1'b1;
                bundle_d.alu_src     = 1'b1;
                bundle_d.alu_control = ALU_PASS_B;
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            bundle_d  = '0;
            imm_src_d = IMM_I;
            use_rs1_d = 1'b0;
            use_rs2_d = 1'b0;
        end
    end

    assign rd_d        = bundle_d.reg_write ? REG_ADDR_W'(instr_d_i[11:7]) : '0;
    assign imm_src_d_o = imm_src_d;
    assign illegal_d_o = illegal_d;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_e_o) begin
            bundle_e <= '0;
            funct3_e <= '0;
            rd_e     <= '0;
            rs1_e    <= '0;
            rs2_e    <= '0;
        end else begin
            bundle_e <= bundle_d;
            funct3_e <= funct3_d;
            rd_e     <= rd_d;
            rs1_e    <= rs1_d;
            rs2_e    <= rs2_d;
        end
    end

    assign alu_control_e_o   = ALU_CTRL_W'(bundle_e.alu_control);
    assign alu_src_e_o       = bundle_e.alu_src;
    assign pc_target_src_e_o = bundle_e.target_src;
    assign pc_src_e_o        = (bundle_e.branch && branch_taken(funct3_e, zero_e_i, lt_e_i, ltu_e_i))
                               || bundle_e.jump;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_m_o  <= 1'b0;
            mem_write_m_o  <= 1'b0;
            result_src_m   <= RES_ALU;
            rd_m_o         <= '0;
            reg_write_w_o  <= 1'b0;
            result_src_w_o <= '0;
            rd_w_o         <= '0;
        end else begin
            reg_write_m_o  <= bundle_e.reg_write;
            mem_write_m_o  <= bundle_e.mem_write;
            result_src_m   <= bundle_e.result_src;
            rd_m_o         <= rd_e;
            reg_write_w_o  <= reg_write_m_o;
            result_src_w_o <= result_src_m;
            rd_w_o         <= rd_m_o;
        end
    end

    hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .load_e      (bundle_e.result_src == RES_MEM),
        .rd_e        (rd_e),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .use_rs1_d   (use_rs1_d),
        .use_rs2_d   (use_rs2_d),
        .pc_src_e    (pc_src_e_o),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .reg_write_m (reg_write_m_o),
        .rd_m        (rd_m_o),
        .reg_write_w (reg_write_w_o),
        .rd_w        (rd_w_o),
        .stall_f     (stall_f_o),
        .stall_d     (stall_d_o),
        .flush_d     (flush_d_o),
        .flush_e     (flush_e_o),
        .fwd_a       (fwd_a_e_o),
        .fwd_b       (fwd_b_e_o)
    );

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_d_o)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (pc_src_e_o)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Pipelined successor to the single-cycle controller for the 5-stage RV32I core.
- Decodes the instruction in the ID stage and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches in EX and generates stall, flush and forwarding selects for the datapath.
- Adds the full RV32I branch set, shifts, xor, sltu, lui and jalr; unknown opcodes decode to a safe bubble rather than X.

Parameters:
ALU_CTRL_W, 4, width of the ALU control code (must be 4 or more to cover ctrl_pkg encodings)
REG_ADDR_W, 5, register index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
instr_d_i  in  32  instruction in ID
zero_e_i  in  1  ALU result == 0 (EX)
lt_e_i  in  1  signed a<b (EX)
ltu_e_i  in  1  unsigned a<b (EX)
imm_src_d_o  out  3  immediate format for ID extender
illegal_d_o  out  1  unknown opcode/funct in ID
stall_f_o  out  1  hold PC
stall_d_o  out  1  hold IF/ID
flush_d_o  out  1  clear IF/ID
flush_e_o  out  1  insert bubble into ID/EX
alu_control_e_o  out  ALU_CTRL_W  ALU op (EX)
alu_src_e_o  out  1  0=reg, 1=imm
fwd_a_e_o  out  2  00 reg file, 01 WB result, 10 MEM ALU result
fwd_b_e_o  out  2  same encoding, operand B
pc_src_e_o  out  1  redirect PC (taken branch or jump)
pc_target_src_e_o  out  1  0=PC+imm, 1=ALU result (jalr)
mem_write_m_o  out  1  store enable (MEM)
reg_write_m_o  out  1  reg write pending (MEM)
rd_m_o  out  REG_ADDR_W  dest register (MEM)
result_src_w_o  out  2  00 ALU, 01 memory, 10 PC+4
reg_write_w_o  out  1  reg file write enable (WB)
rd_w_o  out  REG_ADDR_W  dest register (WB)

Behaviour:
- One clock: clk_i. Reset is synchronous and active-high: rst_i.
- Reset: all stage registers clear to bubble (every control bit 0, rd 0, funct3 0). All registered outputs read 0 the cycle after rst_i is sampled high. Reset mid-operation discards all in-flight instructions; no write or store is issued afterwards.

ID decode (combinational):
- lw: rw=1, imm=I, src=1, res=01.
- sw: imm=S, src=1, mw=1.
- R-type: rw=1, funct3/funct7b5 select.
- I-ALU: rw=1, imm=I, src=1. funct7b5 is honoured only for srai; addi never subtracts.
- Branch: imm=B, branch=1, ALU=SUB.
- jal: rw=1, imm=J, res=10, jump=1.
- jalr: rw=1, imm=I, src=1, ALU=ADD, res=10, jump=1, target_src=1.
- lui: rw=1, imm=U, src=1, ALU=PASS_B.
- Any other opcode or funct: bundle=0, illegal_d_o=1.

Pipeline latency:
- Controls reach EX one cycle after ID, MEM after two, WB after three.
- rs1/rs2 are latched into ID/EX along with the bundle.

EX branch resolution by funct3_e:
- 000 beq: zero.
- 001 bne: !zero.
- 100 blt: lt.
- 101 bge: !lt.
- 110 bltu: ltu.
- 111 bgeu: !ltu.
- 010/011: never taken.
- pc_src_e_o = (branch_e & taken) | jump_e.

Load-use hazard:
- Condition: EX is a load, rd_e != 0, and rd_e matches an rs1_d/rs2_d that the ID instruction actually reads.
- Response: stall_f=stall_d=1 and flush_e=1 for exactly one cycle.

Redirect:
- pc_src_e_o=1 gives flush_d=1 and flush_e=1 in the same cycle.
- Redirect has priority: stall_f and stall_d are forced to 0 when pc_src_e_o=1.

Forwarding, per operand:
- Select 10 if reg_write_m & rd_m!=0 & rd_m==rs_e.
- Otherwise select 01 if reg_write_w & rd_w!=0 & rd_w==rs_e.
- Otherwise select 00.
- MEM wins over WB. x0 is never forwarded.

Flushed or stalled slots:
- A flushed ID/EX slot carries bundle 0, so no side effects reach later stages.
- A stalled IF/ID keeps its instruction and is re-decoded in the next cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Enabled:
  - Adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on each load-use stall cycle; flush_cnt_o increments on each redirect cycle.
  - Both counters clear on rst_i and wrap at 2^32.
- Disabled: ports and logic are absent; all other behaviour is identical.

Decomposition:
- ctrl_pkg holds:
  - alu_op_t: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASS_B=10.
  - imm_src_t: I=000, S=001, B=010, J=011, U=100.
  - result_src_t.
  - opcode constants.
  - ctrl_bundle_t packed struct.
- One sub-module, hazard_unit: load-use detection, redirect priority and forwarding selects. Purely combinational; the pipeline registers stay in the top.

Test Plan:
- lw x5,0(x1) then add x6,x5,x2 -> one cycle with stall_f=stall_d=flush_e=1, then fwd_a_e=01 on add in EX.
- add x3,x1,x2 then sub x4,x3,x3 -> fwd_a_e=fwd_b_e=10 with no stall; with rd=x0 instead, both selects stay 00.
- bne with zero_e_i=0 -> pc_src_e_o=1, flush_d=flush_e=1. Same instruction with zero_e_i=1 -> no redirect.
- jalr x1,8(x2) -> pc_target_src_e_o=1, result_src_w_o=10 and reg_write_w_o=1 three cycles later.
- Opcode 0x7F -> illegal_d_o=1 and all downstream write/store enables 0 through WB.
- rst_i asserted while a sw is in EX -> mem_write_m_o=0 next cycle and every output is 0 thereafter until new fetch.
